// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID register with one outstanding imem request and a one-entry skid
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] BranchTargetE,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic [31:0] ImemRdata,
   input  logic        ImemValid,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        FetchBusyF
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
   state_t state, nxt;
   logic [31:0] skid, discard_addr, target, pc_next, deliver_instr;
   logic go, accept, deliver;
   assign target = BranchTargetE & ~32'd3;
   assign pc_next = PCF + 32'd4;
   assign ImemAddr = (state == DISCARD) ? discard_addr : PCF;
   assign FetchBusyF = ImemReq & ~ImemValid;
   assign go = ~StallF & ~StallD & ~PCSrcE;
   assign accept = (state == FETCH) & ImemReq & ImemValid & go;
   assign deliver = accept | ((state == HOLD) & go);
   assign deliver_instr = (state == HOLD) ? skid : ImemRdata;
   // next state: a redirect with the old request still in flight must wait it out in DISCARD
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = FETCH;
         FETCH:   nxt = PCSrcE ? (ImemValid ? FETCH : DISCARD) :
                        (ImemValid & (StallF | StallD)) ? HOLD : FETCH;
         HOLD:    nxt = (PCSrcE | (~StallF & ~StallD)) ? FETCH : HOLD;
         DISCARD: nxt = ImemValid ? FETCH : DISCARD;
         default: nxt = IDLE;
      endcase
   end
   // PC, skid, request and IF/ID update; redirect beats flush, flush beats stall, stall beats delivery
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ImemReq      <= 1'b0;
         PCF          <= RESET_PC;
         InstrD       <= NOP_INSTR;
         PCPlus4D     <= '0;
         ValidD       <= 1'b0;
         skid         <= '0;
         discard_addr <= RESET_PC;
      end else begin
         state   <= nxt;
         ImemReq <= (nxt == FETCH) || (nxt == DISCARD);
         if (PCSrcE)
            PCF <= target;
         else if (deliver)
            PCF <= pc_next;
         if ((state == FETCH) && (nxt == DISCARD))
            discard_addr <= PCF;
         if ((state == FETCH) && (nxt == HOLD))
            skid <= ImemRdata;
         if (PCSrcE || FlushD || (!StallD && !deliver)) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end else if (!StallD) begin
            InstrD   <= deliver_instr;
            PCPlus4D <= pc_next;
            ValidD   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven, corner-case and randomized model checks of fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'hE1A0_0000;
   logic clk = 1'b0, reset = 1'b0;
   logic StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
   logic [31:0] BranchTargetE = '0;
   logic ImemReq, ImemValid, FetchBusyF, ValidD;
   logic [31:0] ImemAddr, ImemRdata, PCF, InstrD, PCPlus4D;
   logic w_zero = 1'b0;
   logic [31:0] w_tgt = '0;
   logic w_req, w_valid, w_busy, w_vd;
   logic [31:0] w_addr, w_rdata, w_pcf, w_instr, w_p4;
   int n_chk = 0, n_fail = 0;
   int cnt = 0, fixed_lat = 0, rnd_lat = 0, lat, ndel = 0;
   bit rnd_mode = 1'b0;
   logic pend, p_sf, p_sd, p_br, p_v;
   logic [31:0] p_addr, p_tgt, p_instr, p_p4, exp_pc;

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] tgt, pcf, instr, p4;
      logic [1:0]  vr;
   } vec_t;
   vec_t tbl[14];

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'd1;
   endfunction

   assign lat = rnd_mode ? rnd_lat : fixed_lat;
   assign ImemValid = ImemReq && (cnt >= lat);
   assign ImemRdata = ImemValid ? word(ImemAddr) : 32'hDEAD_BEEF;
   assign w_valid = w_req;
   assign w_rdata = word(w_addr);

   always @(posedge clk or negedge reset)
      if (!reset) cnt <= 0;
      else if (ImemReq && !ImemValid) cnt <= cnt + 1;
      else begin
         cnt <= 0;
         rnd_lat <= $urandom_range(0, 3);
      end

   fetch_stage dut (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemRdata(ImemRdata), .ImemValid(ImemValid), .PCF(PCF), .InstrD(InstrD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .reset(reset), .StallF(w_zero), .StallD(w_zero), .FlushD(w_zero),
      .PCSrcE(w_zero), .BranchTargetE(w_tgt), .ImemReq(w_req), .ImemAddr(w_addr),
      .ImemRdata(w_rdata), .ImemValid(w_valid), .PCF(w_pcf), .InstrD(w_instr),
      .PCPlus4D(w_p4), .ValidD(w_vd), .FetchBusyF(w_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // ctl = {StallF, StallD, FlushD, PCSrcE}, vr = {ValidD, ImemReq}
      tbl[0]  = '{4'b0000, 32'h0,   32'h0,   NOP,      32'h0,   2'b01};
      tbl[1]  = '{4'b0000, 32'h0,   32'h4,   32'h1,    32'h4,   2'b11};
      tbl[2]  = '{4'b0000, 32'h0,   32'h8,   32'h2,    32'h8,   2'b11};
      tbl[3]  = '{4'b0000, 32'h0,   32'hC,   32'h3,    32'hC,   2'b11};
      tbl[4]  = '{4'b0010, 32'h0,   32'h10,  NOP,      32'h0,   2'b01};
      tbl[5]  = '{4'b0000, 32'h0,   32'h14,  32'h5,    32'h14,  2'b11};
      tbl[6]  = '{4'b0100, 32'h0,   32'h14,  32'h5,    32'h14,  2'b10};
      tbl[7]  = '{4'b0000, 32'h0,   32'h18,  32'h6,    32'h18,  2'b11};
      tbl[8]  = '{4'b0001, 32'h103, 32'h100, NOP,      32'h0,   2'b01};
      tbl[9]  = '{4'b0000, 32'h0,   32'h104, 32'h41,   32'h104, 2'b11};
      tbl[10] = '{4'b1000, 32'h0,   32'h104, NOP,      32'h0,   2'b00};
      tbl[11] = '{4'b1000, 32'h0,   32'h104, NOP,      32'h0,   2'b00};
      tbl[12] = '{4'b0010, 32'h0,   32'h108, NOP,      32'h0,   2'b01};
      tbl[13] = '{4'b0000, 32'h0,   32'h10C, 32'h43,   32'h10C, 2'b11};
      // reset held three cycles
      for (int k = 0; k < 3; k++) begin
         step;
         chk("rst_pcf", PCF, 32'h0);
         chk("rst_req", ImemReq, 1'b0);
         chk("rst_instr", InstrD, NOP);
         chk("rst_valid", ValidD, 1'b0);
         chk("rst_wrap_pcf", w_pcf, 32'hFFFF_FFF8);
      end
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         {StallF, StallD, FlushD, PCSrcE} = tbl[i].ctl;
         BranchTargetE = tbl[i].tgt;
         step;
         chk($sformatf("row%0d_pcf", i), PCF, tbl[i].pcf);
         chk($sformatf("row%0d_instr", i), InstrD, tbl[i].instr);
         chk($sformatf("row%0d_valid", i), ValidD, tbl[i].vr[1]);
         chk($sformatf("row%0d_req", i), ImemReq, tbl[i].vr[0]);
         if (tbl[i].vr[1]) chk($sformatf("row%0d_p4", i), PCPlus4D, tbl[i].p4);
         chk($sformatf("wrap%0d_pcf", i), w_pcf, 32'hFFFF_FFF8 + 32'(4 * i));
         if (i > 0) begin
            chk($sformatf("wrap%0d_p4", i), w_p4, 32'hFFFF_FFF8 + 32'(4 * i));
            chk($sformatf("wrap%0d_instr", i), w_instr, word(w_p4 - 32'd4));
         end
      end
      {StallF, StallD, FlushD, PCSrcE} = 4'b0000;
      // two wait states: address held, bubbles until the response
      fixed_lat = 2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("ws_req", ImemReq, 1'b1);
         chk("ws_addr", ImemAddr, 32'h10C);
         chk("ws_busy", FetchBusyF, k < 2);
         step;
         if (k < 2) begin
            chk("ws_bubble_valid", ValidD, 1'b0);
            chk("ws_bubble_instr", InstrD, NOP);
         end
      end
      chk("ws_instr", InstrD, 32'h44);
      chk("ws_p4", PCPlus4D, 32'h110);
      chk("ws_valid", ValidD, 1'b1);
      chk("ws_pcf", PCF, 32'h110);
      // full stall while the response arrives parks it in the skid
      step;
      step;
      chk("hold_resp_ready", FetchBusyF, 1'b0);
      StallF = 1'b1;
      StallD = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step;
         chk("hold_req", ImemReq, 1'b0);
         chk("hold_pcf", PCF, 32'h110);
         chk("hold_valid", ValidD, 1'b0);
         chk("hold_instr", InstrD, NOP);
      end
      StallF = 1'b0;
      StallD = 1'b0;
      step;
      chk("hold_rel_instr", InstrD, 32'h45);
      chk("hold_rel_valid", ValidD, 1'b1);
      chk("hold_rel_pcf", PCF, 32'h114);
      chk("hold_rel_req", ImemReq, 1'b1);
      // redirect while a request is outstanding
      PCSrcE = 1'b1;
      BranchTargetE = 32'h40;
      step;
      PCSrcE = 1'b0;
      chk("disc_pcf", PCF, 32'h40);
      chk("disc_addr", ImemAddr, 32'h114);
      chk("disc_req", ImemReq, 1'b1);
      chk("disc_valid", ValidD, 1'b0);
      step;
      chk("disc_addr2", ImemAddr, 32'h114);
      chk("disc_busy2", FetchBusyF, 1'b0);
      chk("disc_valid2", ValidD, 1'b0);
      step;
      chk("disc_done_addr", ImemAddr, 32'h40);
      chk("disc_done_valid", ValidD, 1'b0);
      chk("disc_done_pcf", PCF, 32'h40);
      fixed_lat = 0;
      step;
      chk("disc_tgt_instr", InstrD, 32'h11);
      chk("disc_tgt_p4", PCPlus4D, 32'h44);
      chk("disc_tgt_valid", ValidD, 1'b1);
      // redirect beats stalls in HOLD and drops the skid
      StallF = 1'b1;
      StallD = 1'b1;
      step;
      chk("hr_req", ImemReq, 1'b0);
      chk("hr_instr", InstrD, 32'h11);
      chk("hr_pcf", PCF, 32'h44);
      PCSrcE = 1'b1;
      BranchTargetE = 32'h23;
      step;
      chk("hr_pcf_tgt", PCF, 32'h20);
      chk("hr_valid", ValidD, 1'b0);
      chk("hr_req_again", ImemReq, 1'b1);
      {StallF, StallD, FlushD, PCSrcE} = 4'b0000;
      step;
      chk("hr_next_instr", InstrD, 32'h9);
      chk("hr_next_pcf", PCF, 32'h24);
      chk("hr_next_valid", ValidD, 1'b1);
      // randomized stalls, redirects and memory latency against a program-order model
      reset = 1'b0;
      rnd_mode = 1'b1;
      step;
      step;
      reset = 1'b1;
      exp_pc = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         StallF = ($urandom_range(0, 3) == 0);
         StallD = ($urandom_range(0, 4) == 0);
         PCSrcE = ($urandom_range(0, 15) == 0);
         BranchTargetE = $urandom_range(0, 1023);
         #1;
         chk("rnd_busy", FetchBusyF, ImemReq & ~ImemValid);
         pend = ImemReq && !ImemValid;
         p_addr = ImemAddr;
         {p_sf, p_sd, p_br, p_tgt} = {StallF, StallD, PCSrcE, BranchTargetE};
         {p_instr, p_p4, p_v} = {InstrD, PCPlus4D, ValidD};
         step;
         if (pend && ImemReq) chk("rnd_addr_stable", ImemAddr, p_addr);
         if (p_br) begin
            exp_pc = p_tgt & ~32'd3;
            chk("rnd_redirect_bubble", ValidD, 1'b0);
         end else if (p_sd) begin
            chk("rnd_hold_instr", InstrD, p_instr);
            chk("rnd_hold_p4", PCPlus4D, p_p4);
            chk("rnd_hold_valid", ValidD, p_v);
         end else if (ValidD) begin
            chk("rnd_instr", InstrD, word(exp_pc));
            chk("rnd_p4", PCPlus4D, exp_pc + 32'd4);
            chk("rnd_deliver_under_stallf", p_sf, 1'b0);
            exp_pc = exp_pc + 32'd4;
            ndel++;
         end
         chk("rnd_pcf", PCF, exp_pc);
      end
      chk("rnd_progress", ndel >= 300, 1'b1);
      // asynchronous reset in the middle of a pending request
      {StallF, StallD, FlushD, PCSrcE} = 4'b0000;
      rnd_mode = 1'b0;
      fixed_lat = 3;
      for (int k = 0; k < 20 && !FetchBusyF; k++) step;
      chk("arst_pending", FetchBusyF, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_pcf", PCF, 32'h0);
      chk("arst_req", ImemReq, 1'b0);
      chk("arst_valid", ValidD, 1'b0);
      chk("arst_instr", InstrD, NOP);
      step;
      step;
      reset = 1'b1;
      fixed_lat = 0;
      step;
      chk("arst_idle_req", ImemReq, 1'b1);
      chk("arst_idle_pcf", PCF, 32'h0);
      chk("arst_idle_valid", ValidD, 1'b0);
      step;
      chk("arst_first_instr", InstrD, 32'h1);
      chk("arst_first_pcf", PCF, 32'h4);
      chk("arst_first_valid", ValidD, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
